// File: rtl/instr_loader.sv
// Boot-time instruction loader: assembles little-endian 32-bit words from a byte
// stream, writes them sequentially into instruction memory, then releases the core.
module instr_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [31:0]       WD,
    output logic [ADDR_W-1:0] WA,
    output logic              WE,
    output logic              ControlSignal,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, LOAD, FINISH, RUN} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       partial;
    logic [ADDR_W:0]   last_idx;

    logic len_ok;
    logic accept;
    logic last_word;

    assign len_ok    = (len != '0) && (len <= DEPTH);
    assign accept    = byte_valid && byte_ready;
    assign last_word = ({1'b0, word_idx} == last_idx);

    // byte_ready stays high through each mid-load WE so streaming never stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_idx      <= '0;
            word_idx      <= '0;
            partial       <= '0;
            last_idx      <= '0;
            WD            <= '0;
            WA            <= '0;
            WE            <= 1'b0;
            ControlSignal <= 1'b0;
            byte_ready    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            WE   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        if (len_ok) begin
                            state         <= LOAD;
                            err           <= 1'b0;
                            ControlSignal <= 1'b0;
                            byte_ready    <= 1'b1;
                            busy          <= 1'b1;
                            word_idx      <= '0;
                            byte_idx      <= '0;
                            last_idx      <= len - 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: partial[7:0]   <= byte_data;
                            2'd1: partial[15:8]  <= byte_data;
                            2'd2: partial[23:16] <= byte_data;
                            default: begin
                                WE <= 1'b1;
                                WD <= {byte_data, partial};
                                WA <= word_idx;
                                if (last_word) begin
                                    state      <= FINISH;
                                    byte_ready <= 1'b0;
                                end else begin
                                    word_idx <= word_idx + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                FINISH: begin
                    state         <= RUN;
                    busy          <= 1'b0;
                    ControlSignal <= 1'b1;
                    done          <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random byte streams compared against a
// word-level memory model, plus reset, illegal-length and reload scenarios.
module tb_instr_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [31:0]       WD;
    logic [ADDR_W-1:0] WA;
    logic              WE;
    logic              ControlSignal;
    logic              busy;
    logic              done;
    logic              err;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .WD(WD), .WA(WA), .WE(WE), .ControlSignal(ControlSignal),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] wa;
        logic [31:0]       wd;
        int                cyc;
    } wr_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    wr_t  wr_q[$];
    int   done_count;
    int   done_cyc;
    int   cs_rise_cyc;
    logic cs_prev = 1'b0;

    logic [7:0]  stim [0:255];
    logic [31:0] exp_words [0:63];

    always @(posedge clk) cycle++;

    // Records every memory write and the release/done events for later comparison
    always @(negedge clk) begin
        if (WE === 1'b1) wr_q.push_back('{WA, WD, cycle});
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cycle;
        end
        if (ControlSignal === 1'b1 && cs_prev !== 1'b1) cs_rise_cyc = cycle;
        cs_prev = ControlSignal;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clearMonitor();
        wr_q.delete();
        done_count  = 0;
        done_cyc    = -1;
        cs_rise_cyc = -1;
    endtask

    task automatic fillRandom(input int nbytes);
        for (int i = 0; i < nbytes; i++) stim[i] = 8'($urandom);
    endtask

    // Little-endian packing: byte 4w+k carries weight 256**k
    task automatic buildModel(input int nwords);
        for (int w = 0; w < nwords; w++)
            exp_words[w] = 32'(stim[4*w]) + (32'(stim[4*w+1]) << 8)
                         + (32'(stim[4*w+2]) << 16) + (32'(stim[4*w+3]) << 24);
    endtask

    task automatic startPulse(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = 7'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic startLoad(input int l);
        clearMonitor();
        startPulse(l);
    endtask

    task automatic applyStimulus(input int nbytes, input int pct);
        int  i = 0;
        int  guard = 0;
        logic acc;
        while (i < nbytes && guard < 20000) begin
            @(negedge clk);
            byte_valid = ($urandom_range(99) < pct);
            byte_data  = stim[i];
            acc = byte_valid && byte_ready;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        checkOutput("stream_complete", 32'(i), 32'(nbytes));
    endtask

    task automatic verifyLoad(input int l, input string tag);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_we_count"}, 32'(wr_q.size()), 32'(l));
        for (int i = 0; i < l && i < wr_q.size(); i++) begin
            checkOutput({tag, "_wa"}, 32'(wr_q[i].wa), 32'(i));
            checkOutput({tag, "_wd"}, wr_q[i].wd, exp_words[i]);
        end
        checkOutput({tag, "_done_count"}, 32'(done_count), 32'd1);
        if (wr_q.size() > 0) begin
            checkOutput({tag, "_cs_rise"}, 32'(cs_rise_cyc), 32'(wr_q[wr_q.size()-1].cyc + 1));
            checkOutput({tag, "_done_cyc"}, 32'(done_cyc), 32'(wr_q[wr_q.size()-1].cyc + 1));
        end
        checkOutput({tag, "_cs_high"}, 32'(ControlSignal), 32'd1);
        checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_WD"}, WD, 32'd0);
        checkOutput({tag, "_WA"}, 32'(WA), 32'd0);
        checkOutput({tag, "_WE"}, 32'(WE), 32'd0);
        checkOutput({tag, "_cs"}, 32'(ControlSignal), 32'd0);
        checkOutput({tag, "_ready"}, 32'(byte_ready), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int gaps;
        reset      = 1'b1;
        start      = 1'b0;
        len        = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        clearMonitor();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkIdleOutputs("reset");

        // Known RISC-V instructions: addi a0,x0,0 / addi a1,x0,1
        $display("[TB] test 1: fixed two-word load");
        stim[0] = 8'h13; stim[1] = 8'h05; stim[2] = 8'h00; stim[3] = 8'h00;
        stim[4] = 8'h93; stim[5] = 8'h05; stim[6] = 8'h10; stim[7] = 8'h00;
        buildModel(2);
        startLoad(2);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_ready", 32'(byte_ready), 32'd1);
        applyStimulus(8, 100);
        verifyLoad(2, "t1");
        if (wr_q.size() == 2) begin
            checkOutput("t1_word0_const", wr_q[0].wd, 32'h00000513);
            checkOutput("t1_word1_const", wr_q[1].wd, 32'h00100593);
        end

        $display("[TB] test 2: random valid gaps, len=4");
        fillRandom(16);
        buildModel(4);
        startLoad(4);
        applyStimulus(16, 50);
        verifyLoad(4, "t2");

        $display("[TB] test 3: illegal lengths");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        startLoad(0);
        checkOutput("t3_err_len0", 32'(err), 32'd1);
        checkOutput("t3_busy_len0", 32'(busy), 32'd0);
        startLoad(65);
        checkOutput("t3_err_len65", 32'(err), 32'd1);
        checkOutput("t3_busy_len65", 32'(busy), 32'd0);
        checkOutput("t3_ready_len65", 32'(byte_ready), 32'd0);
        checkOutput("t3_cs_len65", 32'(ControlSignal), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t3_no_we", 32'(wr_q.size()), 32'd0);

        $display("[TB] test 4: reset mid-load");
        fillRandom(8);
        startLoad(2);
        checkOutput("t4_err_cleared", 32'(err), 32'd0);
        applyStimulus(6, 100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkIdleOutputs("t4_after_reset");
        repeat (3) @(negedge clk);
        checkOutput("t4_one_write", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) checkOutput("t4_write_wa0", 32'(wr_q[0].wa), 32'd0);
        fillRandom(8);
        buildModel(2);
        startLoad(2);
        applyStimulus(8, 100);
        verifyLoad(2, "t4_fresh");

        $display("[TB] test 5: reload from RUN, start ignored during LOAD");
        fillRandom(4);
        buildModel(1);
        startLoad(1);
        checkOutput("t5_cs_fall", 32'(ControlSignal), 32'd0);
        startPulse(3);
        checkOutput("t5_busy_after_ignored", 32'(busy), 32'd1);
        checkOutput("t5_err_after_ignored", 32'(err), 32'd0);
        applyStimulus(4, 100);
        verifyLoad(1, "t5");

        $display("[TB] test 6: full-depth continuous load");
        fillRandom(4 * DEPTH);
        buildModel(DEPTH);
        startLoad(DEPTH);
        applyStimulus(4 * DEPTH, 100);
        verifyLoad(DEPTH, "t6");
        gaps = 0;
        for (int i = 1; i < wr_q.size(); i++)
            if (wr_q[i].cyc - wr_q[i-1].cyc != 4) gaps++;
        checkOutput("t6_spacing_gaps", 32'(gaps), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
